vam16_job_sequencer: RTL

//   Upstream feeder for the VAM16 top. Buffers incoming 32-bit operand words in a FIFO,

---
 rtl/vam16_job_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vam16_job_sequencer.sv
// vam16_job_sequencer: upstream feeder for the VAM16 top.
// Operand words are queued in a small circular FIFO. One VAM16 job runs at a
// time: the word goes out on bus32, start pulses for one cycle, and the block
// waits for readyPulse. The result is held for the downstream consumer, which
// takes it with a valid/ready handshake. A watchdog retires any job whose
// readyPulse never arrives and reports it with err set.
module vam16_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_data_i,
  output logic [31:0]              vam_bus32_o,
  output logic                     vam_start_o,
  input  logic [31:0]              vam_rslt_i,
  input  logic                     vam_ready_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_data_o,
  output logic                     out_err_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int LvlW = PtrW + 1;
  localparam int WdW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2
  } state_e;

  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wrPtr_q;
  logic [PtrW-1:0] rdPtr_q;
  logic [LvlW-1:0] level_q;
  logic [LvlW-1:0] level_d;

  state_e          state_q;
  logic [WdW-1:0]  wdog_q;
  logic [31:0]     bus_q;
  logic            start_q;
  logic            outValid_q;
  logic [31:0]     outData_q;
  logic            outErr_q;

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            slotFree;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LvlW'(DEPTH));
  assign push     = in_valid_i & ~full;
  // A new job may only start when its result is guaranteed a place to land.
  assign slotFree = ~outValid_q | out_ready_i;
  assign pop      = (state_q == StIdle) & ~empty & slotFree;

  // Occupancy bookkeeping: a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wrPtr_q] <= in_data_i;
    end
  end

  // FIFO pointers and level; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PtrW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PtrW'(1);
      end
      level_q <= level_d;
    end
  end

  // Job FSM with registered outputs; a load of the result register overrides a drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wdog_q     <= '0;
      bus_q      <= '0;
      start_q    <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outErr_q   <= 1'b0;
    end else begin
      if (outValid_q && out_ready_i) begin
        outValid_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (pop) begin
            bus_q   <= mem_q[rdPtr_q];
            start_q <= 1'b1;
            state_q <= StLaunch;
          end
        end
        StLaunch: begin
          start_q <= 1'b0;
          wdog_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (vam_ready_i) begin
            outData_q  <= vam_rslt_i;
            outErr_q   <= 1'b0;
            outValid_q <= 1'b1;
            state_q    <= StIdle;
          end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
            outData_q  <= '0;
            outErr_q   <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            wdog_q <= wdog_q + WdW'(1);
          end
        end
        default: begin
          start_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready_o  = ~full;
  assign level_o     = level_q;
  assign vam_bus32_o = bus_q;
  assign vam_start_o = start_q;
  assign out_valid_o = outValid_q;
  assign out_data_o  = outData_q;
  assign out_err_o   = outErr_q;

endmodule
